// File: rtl/counter_bcd_n_digits.sv
// N-digit BCD up/down counter with tick prescaler, parallel load, wrap/saturate and
// active-low 7-segment decode. Define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module counter_bcd_n_digits #(
  parameter int DIGITS   = 3,
  parameter int TICK_DIV = 50_000_000,
  parameter int WRAP     = 1
) (
  input  logic                  CLOCK_50,
  input  logic                  aclr,
  input  logic                  enable,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   HEX,
  output logic                  tick,
  output logic                  at_max,
  output logic                  at_min,
  output logic                  wrap
);

  localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]         presc_q, presc_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic                  wrap_q, wrap_d;
  logic [4*DIGITS-1:0]   stepped;
  logic [4*DIGITS-1:0]   clamped;
  logic                  carry_out;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign tick = enable && (presc_q == PRESC_LAST);

  // Ripple the +/-1 through all digits; a carry out of the top digit means
  // the count was at its limit and the stepped value is already the wrapped one.
  always_comb begin
    logic       carry;
    logic [3:0] d;
    carry   = 1'b1;
    stepped = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      d = bcd_q[4*i +: 4];
      if (carry) begin
        if (up_dn) begin
          if (d == 4'd9) stepped[4*i +: 4] = 4'd0;
          else begin
            stepped[4*i +: 4] = d + 4'd1;
            carry             = 1'b0;
          end
        end else begin
          if (d == 4'd0) stepped[4*i +: 4] = 4'd9;
          else begin
            stepped[4*i +: 4] = d - 4'd1;
            carry             = 1'b0;
          end
        end
      end
    end
    carry_out = carry;
  end

  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      clamped[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
    end
  end

  always_comb begin
    presc_d = presc_q;
    bcd_d   = bcd_q;
    wrap_d  = 1'b0;
    if (load) begin
      bcd_d   = clamped;
      presc_d = '0;
    end else if (enable) begin
      if (tick) begin
        presc_d = '0;
        if (!carry_out) begin
          bcd_d = stepped;
        end else if (WRAP != 0) begin
          bcd_d  = stepped;
          wrap_d = 1'b1;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (aclr) begin
      presc_q <= '0;
      bcd_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      bcd_q   <= bcd_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bcd    = bcd_q;
  assign wrap   = wrap_q;
  assign at_max = (bcd_q == {DIGITS{4'h9}});
  assign at_min = (bcd_q == '0);

  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    HEX        = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above        = zero_above && (bcd_q[4*i +: 4] == 4'd0);
      HEX[7*i +: 7]     = seg7(bcd_q[4*i +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
      if (zero_above && (i != 0)) HEX[7*i +: 7] = 7'h7F;
`endif
    end
  end

endmodule

// File: tb/tb_counter_bcd_n_digits.sv
// Bench for counter_bcd_n_digits: directed + random stimulus against a decimal-value
// reference model; expected outputs queued per cycle and checked by a monitor.
module tb_counter_bcd_n_digits;

  localparam int DIG    = 3;
  localparam int TD     = 4;
  localparam int WRAP_P = 1;
  localparam int MAXV   = 999;
  localparam int W      = 4*DIG + 7*DIG + 4;

  logic               CLOCK_50 = 1'b0;
  logic               aclr     = 1'b0;
  logic               enable   = 1'b0;
  logic               up_dn    = 1'b1;
  logic               load     = 1'b0;
  logic [4*DIG-1:0]   load_val = '0;
  logic [4*DIG-1:0]   bcd;
  logic [7*DIG-1:0]   HEX;
  logic               tick, at_max, at_min, wrap;

  always #5 CLOCK_50 = ~CLOCK_50;

  counter_bcd_n_digits #(.DIGITS(DIG), .TICK_DIV(TD), .WRAP(WRAP_P)) dut (
    .CLOCK_50 (CLOCK_50),
    .aclr     (aclr),
    .enable   (enable),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .bcd      (bcd),
    .HEX      (HEX),
    .tick     (tick),
    .at_max   (at_max),
    .at_min   (at_min),
    .wrap     (wrap)
  );

  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_bad = 0;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // Reference model state: count as a plain decimal integer
  int m_val   = 0;
  int m_presc = 0;
  bit m_wrap  = 0;
  bit m_known = 0;

  function automatic logic [W-1:0] model_out(input bit tk);
    logic [4*DIG-1:0] eb;
    logic [7*DIG-1:0] eh;
    int p;
    int d;
    p = 1;
    for (int i = 0; i < DIG; i++) begin
      d = (m_val / p) % 10;
      eb[4*i +: 4] = 4'(d);
      eh[7*i +: 7] = seg_tab[d];
`ifdef LEADING_ZERO_BLANK_EN
      if (i > 0 && m_val < p) eh[7*i +: 7] = 7'h7F;
`endif
      p = p * 10;
    end
    return {eb, eh, tk, (m_val == MAXV), (m_val == 0), m_wrap};
  endfunction

  function automatic int clamp_val(input logic [4*DIG-1:0] lv);
    int v;
    int p;
    int n;
    v = 0;
    p = 1;
    for (int i = 0; i < DIG; i++) begin
      n = int'(lv[4*i +: 4]);
      if (n > 9) n = 9;
      v = v + n * p;
      p = p * 10;
    end
    return v;
  endfunction

  task automatic cyc(input bit a, input bit e, input bit u, input bit l,
                     input logic [4*DIG-1:0] lv);
    bit tk;
    @(negedge CLOCK_50);
    #1;
    aclr     = a;
    enable   = e;
    up_dn    = u;
    load     = l;
    load_val = lv;
    tk = e && (m_presc == TD - 1);
    if (m_known) exp_q.push_back(model_out(tk));
    if (a) begin
      m_val = 0; m_presc = 0; m_wrap = 0; m_known = 1;
    end else if (l) begin
      m_val = clamp_val(lv); m_presc = 0; m_wrap = 0;
    end else if (e) begin
      m_wrap = 0;
      if (tk) begin
        m_presc = 0;
        if (u) begin
          if (m_val == MAXV) begin
            if (WRAP_P != 0) begin m_val = 0; m_wrap = 1; end
          end else m_val = m_val + 1;
        end else begin
          if (m_val == 0) begin
            if (WRAP_P != 0) begin m_val = MAXV; m_wrap = 1; end
          end else m_val = m_val - 1;
        end
      end else begin
        m_presc = m_presc + 1;
      end
    end else begin
      m_wrap = 0;
    end
  endtask

  // Monitor: one registered snapshot per cycle, after the driver has settled inputs
  initial begin
    logic [W-1:0] exp_v;
    logic [W-1:0] act_v;
    forever begin
      @(negedge CLOCK_50);
      #2;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {bcd, HEX, tick, at_max, at_min, wrap};
        n_vec++;
        if (act_v !== exp_v) begin
          n_bad++;
          $display("FAIL vec%0d t=%0t: got bcd=%h HEX=%h tick=%b max=%b min=%b wrap=%b, need bcd=%h HEX=%h tick=%b max=%b min=%b wrap=%b",
                   n_vec, $time, act_v[W-1 -: 4*DIG], act_v[3+7*DIG:4], act_v[3], act_v[2], act_v[1], act_v[0],
                   exp_v[W-1 -: 4*DIG], exp_v[3+7*DIG:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    n_bad++;
    $display("FAIL watchdog: time limit reached with %0d vectors queued, need 0", exp_q.size());
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    int sel;
    logic [4*DIG-1:0] rv;
    bit ud;
    // Reset, then count up: tick every 4th cycle
    cyc(1, 1, 1, 0, '0);
    repeat (12) cyc(0, 1, 1, 0, '0);
    // Up through all 9s
    cyc(0, 1, 1, 1, 12'h998);
    repeat (10) cyc(0, 1, 1, 0, '0);
    // Down through all 0s
    cyc(0, 1, 0, 1, 12'h001);
    repeat (10) cyc(0, 1, 0, 0, '0);
    // Freeze mid-count
    cyc(0, 1, 1, 1, 12'h042);
    repeat (2) cyc(0, 1, 1, 0, '0);
    repeat (10) cyc(0, 0, 1, 0, '0);
    repeat (6) cyc(0, 1, 1, 0, '0);
    // Clamp, load vs reset, load vs tick
    cyc(0, 1, 1, 1, 12'hAF3);
    cyc(0, 1, 1, 0, '0);
    cyc(1, 1, 1, 1, 12'h555);
    repeat (3) cyc(0, 1, 1, 0, '0);
    cyc(0, 1, 1, 1, 12'h123);
    repeat (2) cyc(0, 1, 1, 0, '0);
    // Leading-zero display case
    cyc(0, 1, 1, 1, 12'h007);
    repeat (2) cyc(0, 0, 1, 0, '0);
    // Random traffic
    ud = 1'b1;
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 19) == 0) ud = ~ud;
      sel = $urandom_range(0, 3);
      case (sel)
        0:       rv = 12'h998;
        1:       rv = 12'h001;
        2:       rv = 12'h999;
        default: rv = 12'($urandom);
      endcase
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0), ud,
          ($urandom_range(0, 24) == 0), rv);
    end
    repeat (3) @(negedge CLOCK_50);
    #3;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d vectors left unchecked, need 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
